// File: rtl/obj_field_manager.sv
// Scrolling-object engine: N slots swept one per clock after each frame tick,
// handling spawn, motion, animation, player collision, score/health and game state.
module obj_field_manager #(
  parameter int NUM_OBJ      = 8,
  parameter int SCREEN_WIDTH = 1023,
  parameter int CHAR_WIDTH   = 20,
  parameter int CHAR_HEIGHT  = 20,
  parameter int OBJ_HEIGHT   = 20,
  parameter int NUM_LIVES    = 3,
  parameter int SCORE_W      = 10,
  parameter int SPAWN_THRESH = 2,
  parameter int VPOS_MIN     = 230
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   frame_tick,
  input  logic                   start,
  input  logic [3:0]             speed,
  input  logic [31:0]            random,
  input  logic [9:0]             p_vpos,
  output logic [26*NUM_OBJ-1:0]  p_objs,
  output logic [SCORE_W-1:0]     score,
  output logic [2:0]             health,
  output logic [1:0]             state,
  output logic                   sweep_done
);
  localparam int IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

  typedef enum logic [1:0] {ST_START = 2'd0, ST_PLAY = 2'd1, ST_OVER = 2'd2} st_e;

  typedef struct packed {
    logic [2:0]  frame;
    logic [1:0]  id;
    logic [10:0] hpos;
    logic [9:0]  vpos;
  } slot_t;

  st_e                      st, st_nxt;
  slot_t [NUM_OBJ-1:0]      slots;
  slot_t                    cur, slot_nxt;
  logic [IW-1:0]            idx;
  logic [2:0]               fcnt;
  logic                     busy, spawned, slot_spawn, hit, clr;
  logic [SCORE_W-1:0]       score_nxt;
  logic [2:0]               health_nxt;
  logic                     unused_rnd;

  assign unused_rnd = ^random[31:16];
  assign p_objs     = slots;
  assign state      = st;

  always_ff @(posedge clock) begin
    if (!reset_n) st <= ST_START;
    else          st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_START: if (start) st_nxt = ST_PLAY;
      ST_PLAY:  if (sweep_done && health == 3'd0) st_nxt = ST_OVER;
      ST_OVER:  if (start) st_nxt = ST_START;
      default:  st_nxt = ST_START;
    endcase
  end

  // Per-slot evaluation on pre-move values; at most one slot is touched per clock.
  always_comb begin
    cur        = slots[idx];
    slot_nxt   = cur;
    score_nxt  = score;
    health_nxt = health;
    slot_spawn = 1'b0;
    hit = (cur.hpos < 11'(CHAR_WIDTH)) &&
          ({1'b0, cur.vpos} < {1'b0, p_vpos} + 11'(CHAR_HEIGHT)) &&
          ({1'b0, cur.vpos} + 11'(OBJ_HEIGHT) > {1'b0, p_vpos});
    if (cur != '0) begin
      if (hit) begin
        slot_nxt = '0;
        case (cur.id)
          2'd0:    if (score != '1) score_nxt = score + 1'b1;
          2'd1:    if (health != 3'd0) health_nxt = health - 3'd1;
          2'd2:    if (health < 3'(NUM_LIVES)) health_nxt = health + 3'd1;
          default: ;
        endcase
      end else if (cur.hpos <= {7'd0, speed}) begin
        slot_nxt = '0;
      end else begin
        slot_nxt.hpos = cur.hpos - {7'd0, speed};
        if (fcnt == 3'd0) slot_nxt.frame = cur.frame + 3'd1;
      end
    end else if (!spawned && random[5:0] < 6'(SPAWN_THRESH)) begin
      slot_spawn     = 1'b1;
      slot_nxt.frame = 3'd0;
      slot_nxt.id    = (random[7:6] == 2'd3) ? 2'd0 : random[7:6];
      slot_nxt.hpos  = 11'(SCREEN_WIDTH);
      slot_nxt.vpos  = 10'(VPOS_MIN) + {2'b00, random[15:8]};
    end
  end

  // Anything heading into START (reset, OVER->START, bad encoding) wipes the field.
  assign clr = !reset_n || (st_nxt == ST_START);

  always_ff @(posedge clock) begin
    if (clr) begin
      slots      <= '0;
      score      <= '0;
      health     <= 3'(NUM_LIVES);
      sweep_done <= 1'b0;
      fcnt       <= 3'd0;
      idx        <= '0;
      spawned    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      if (st == ST_PLAY) begin
        if (busy) begin
          slots[idx] <= slot_nxt;
          score      <= score_nxt;
          health     <= health_nxt;
          if (slot_spawn) spawned <= 1'b1;
          if (idx == IW'(NUM_OBJ - 1)) begin
            busy       <= 1'b0;
            sweep_done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end else if (frame_tick && !(sweep_done && health == 3'd0)) begin
          busy    <= 1'b1;
          idx     <= '0;
          spawned <= 1'b0;
          fcnt    <= fcnt + 3'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_obj_field_manager.sv
// Directed bench for obj_field_manager: reset, spawn, motion/animation,
// multi-collision scoring, health, game-state flow.
module tb_obj_field_manager;
  localparam int N  = 8;
  localparam int SW = 2;  // narrow score so saturation is reachable quickly

  logic            clock = 0, reset_n = 0, frame_tick = 0, start = 0;
  logic [3:0]      speed = 0;
  logic [31:0]     random = 32'h3F;
  logic [9:0]      p_vpos = 0;
  logic [26*N-1:0] p_objs;
  logic [SW-1:0]   score;
  logic [2:0]      health;
  logic [1:0]      state;
  logic            sweep_done;
  int              n_tests = 0, n_fail = 0;

  obj_field_manager #(.NUM_OBJ(N), .SCORE_W(SW)) dut (
    .clock(clock), .reset_n(reset_n), .frame_tick(frame_tick), .start(start),
    .speed(speed), .random(random), .p_vpos(p_vpos), .p_objs(p_objs),
    .score(score), .health(health), .state(state), .sweep_done(sweep_done)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] mk(int fr, int id, int h, int v);
    return {3'(fr), 2'(id), 11'(h), 10'(v)};
  endfunction

  function automatic logic [25:0] slot(int i);
    return p_objs[26*i +: 26];
  endfunction

  task automatic do_reset();
    @(negedge clock); reset_n = 0; frame_tick = 0; start = 0;
    @(negedge clock); reset_n = 1;
  endtask

  task automatic pulse_start();
    @(negedge clock) start = 1;
    @(negedge clock) start = 0;
  endtask

  task automatic frame();
    bit seen;
    seen = 0;
    @(negedge clock) frame_tick = 1;
    @(negedge clock) frame_tick = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (sweep_done) seen = 1;
    end
    if (!seen) chk("sweep_timeout", 32'(seen), 1);
  endtask

  task automatic approach(input int n);
    speed = 15; random = 32'h3F;
    repeat (n) frame();
  endtask

  initial begin
    bit          seen;
    logic [25:0] s;

    // reset state, tick ignored in START
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_health", health, 3);
    chk("rst_score", score, 0);
    chk("rst_objs", 32'(|p_objs), 0);
    chk("rst_done", sweep_done, 0);
    random = 0;
    @(negedge clock) frame_tick = 1;
    @(negedge clock) frame_tick = 0;
    repeat (10) @(negedge clock);
    chk("start_tick_ignored", 32'(|p_objs), 0);
    pulse_start();
    chk("start_to_play", state, 1);

    // spawn: one per sweep, lowest empty slot
    speed = 0; random = 32'h0000_4040; p_vpos = 0;
    frame();
    chk("spawn_s0", slot(0), mk(0, 1, 1023, 294));
    chk("spawn_s1_empty", slot(1), 0);
    frame();
    chk("spawn2_s0", slot(0), mk(0, 1, 1023, 294));
    chk("spawn2_s1", slot(1), mk(0, 1, 1023, 294));
    chk("spawn2_s2_empty", slot(2), 0);
    pulse_start();
    chk("start_in_play_ignored", state, 1);

    // reset while slot 3 is being processed
    @(negedge clock) frame_tick = 1;
    @(negedge clock) frame_tick = 0;
    repeat (3) @(negedge clock);
    reset_n = 0;
    @(negedge clock);
    chk("midrst_objs", 32'(|p_objs), 0);
    chk("midrst_score", score, 0);
    chk("midrst_health", health, 3);
    chk("midrst_state", state, 0);
    reset_n = 1;
    seen = 0;
    repeat (12) begin
      @(negedge clock);
      if (sweep_done) seen = 1;
    end
    chk("midrst_no_done", 32'(seen), 0);

    // motion and animation frame
    do_reset(); pulse_start();
    p_vpos = 0; speed = 0; random = 0;
    frame();
    chk("mv_spawn", slot(0), mk(0, 0, 1023, 230));
    speed = 15; random = 32'h3F;
    for (int k = 2; k <= 68; k++) begin
      frame();
      if (k == 8)  chk("mv_k8", slot(0), mk(1, 0, 918, 230));
      if (k == 56) chk("mv_k56", slot(0), mk(7, 0, 198, 230));
      if (k == 64) chk("mv_k64_wrap", slot(0), mk(0, 0, 78, 230));
    end
    speed = 6; frame();
    chk("mv_12", slot(0), mk(0, 0, 12, 230));
    speed = 5; frame();
    chk("mv_7", slot(0), mk(0, 0, 7, 230));
    frame();
    chk("mv_2", slot(0), mk(0, 0, 2, 230));
    frame();
    chk("mv_escaped", slot(0), 0);
    chk("mv_no_other", 32'(|p_objs), 0);
    chk("mv_score", score, 0);
    chk("mv_health", health, 3);

    // three score objects hit in one sweep, then saturation
    do_reset(); pulse_start();
    p_vpos = 0; speed = 0; random = 0;
    repeat (3) frame();
    chk("mc_s2", slot(2), mk(0, 0, 1023, 230));
    approach(67);
    chk("mc_s1_near", slot(1), mk(0, 0, 18, 230));
    p_vpos = 230; frame();
    chk("mc_score3", score, 3);
    chk("mc_cleared", 32'(|p_objs), 0);
    p_vpos = 0; speed = 0; random = 0; frame();
    approach(67);
    p_vpos = 230; frame();
    chk("mc_score_sat", score, 3);
    chk("mc_sat_cleared", slot(0), 0);

    // health: cap, decrement, OVER
    do_reset(); pulse_start();
    p_vpos = 0; speed = 0; random = 32'h0000_4080;
    frame();
    chk("h2_spawn", slot(0), mk(0, 2, 1023, 294));
    approach(67);
    p_vpos = 300; frame();
    chk("h2_capped", health, 3);
    chk("h2_cleared", slot(0), 0);
    p_vpos = 0; speed = 0; random = 32'h0000_4040; frame();
    approach(67);
    p_vpos = 300; frame();
    chk("h1_dec", health, 2);
    p_vpos = 0; speed = 0; random = 32'h0000_4040;
    repeat (2) frame();
    approach(66);
    random = 0; frame();  // third, harmless object spawns far right in slot 2
    p_vpos = 300; random = 32'h3F;
    @(negedge clock) frame_tick = 1;
    @(negedge clock) frame_tick = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (sweep_done) seen = 1;
    end
    chk("hl_done", 32'(seen), 1);
    chk("hl_health0", health, 0);
    chk("hl_state_at_done", state, 1);
    @(negedge clock);
    chk("hl_over", state, 2);
    s = slot(2);
    chk("hl_s2", 32'(s[22:0]), 32'(mk(0, 0, 1008, 230)));

    // OVER freezes the field
    speed = 15; random = 0;
    @(negedge clock) frame_tick = 1;
    @(negedge clock) frame_tick = 0;
    repeat (12) @(negedge clock);
    chk("over_frozen_s2", 32'(slot(2)), 32'(s));
    chk("over_no_spawn", slot(3), 0);
    chk("over_health", health, 0);
    chk("over_state", state, 2);

    // OVER -> START clears, second start -> PLAY
    pulse_start();
    chk("over_to_start", state, 0);
    @(negedge clock);
    chk("restart_objs", 32'(|p_objs), 0);
    chk("restart_health", health, 3);
    chk("restart_score", score, 0);
    pulse_start();
    chk("restart_play", state, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
